// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and flag controller for an asynchronous FIFO: write pointer
// (binary and Gray), read-pointer synchronizer, full/almost-full, occupancy, overflow.
module wptr_full_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 8,
  parameter int PTR_WIDTH    = 3,
  parameter int AFULL_THRESH = 6
) (
  input  logic               wclk,
  input  logic               w_rst,
  input  logic               wen,
  input  logic [PTR_WIDTH:0] g_rptr,
  input  logic               ovf_clr,
  output logic [PTR_WIDTH:0] b_wptr,
  output logic [PTR_WIDTH:0] g_wptr,
  output logic               full,
  output logic               almost_full,
  output logic [PTR_WIDTH:0] wlevel,
  output logic               overflow
);

  // The full comparison inverts the top two Gray bits, so at least two address bits are needed.
  if (DATA_WIDTH < 1 || PTR_WIDTH < 2 || DEPTH != (1 << PTR_WIDTH) ||
      AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_param_check
    $error("wptr_full_ctrl: inconsistent DEPTH/PTR_WIDTH/AFULL_THRESH/DATA_WIDTH");
  end

  localparam logic [PTR_WIDTH:0] AF_THRESH = AFULL_THRESH[PTR_WIDTH:0];
  localparam logic [PTR_WIDTH:0] PTR_ONE   = {{PTR_WIDTH{1'b0}}, 1'b1};

  logic [PTR_WIDTH:0] rq1_reg;
  logic [PTR_WIDTH:0] rq2_reg;
  logic [PTR_WIDTH:0] b_wptr_reg;
  logic [PTR_WIDTH:0] g_wptr_reg;
  logic               full_reg;
  logic               almost_full_reg;
  logic [PTR_WIDTH:0] wlevel_reg;
  logic               overflow_reg;

  logic               wr_accept;
  logic [PTR_WIDTH:0] b_next;
  logic [PTR_WIDTH:0] g_next;
  logic [PTR_WIDTH:0] rbin;
  logic [PTR_WIDTH:0] rq2_wrapped;
  logic               full_next;
  logic [PTR_WIDTH:0] wlevel_next;
  logic               almost_full_next;
  logic               overflow_next;

  // Two-flop synchronizer: the only consumer of the asynchronous read pointer.
  always_ff @(posedge wclk or posedge w_rst) begin
    if (w_rst) begin
      rq1_reg <= '0;
      rq2_reg <= '0;
    end else begin
      rq1_reg <= g_rptr;
      rq2_reg <= rq1_reg;
    end
  end

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  for (genvar gi = 0; gi <= PTR_WIDTH; gi++) begin : g_rbin
    assign rbin[gi] = ^rq2_reg[PTR_WIDTH:gi];
  end

  assign rq2_wrapped = {~rq2_reg[PTR_WIDTH:PTR_WIDTH-1], rq2_reg[PTR_WIDTH-2:0]};

  always_comb begin
    wr_accept        = wen & ~full_reg;
    b_next           = wr_accept ? (b_wptr_reg + PTR_ONE) : b_wptr_reg;
    g_next           = b_next ^ (b_next >> 1);
    full_next        = (g_next == rq2_wrapped);
    wlevel_next      = b_next - rbin;
    almost_full_next = (wlevel_next >= AF_THRESH);
    overflow_next    = overflow_reg;
    // A fresh overflow takes priority over a coincident clear.
    if (wen && full_reg) begin
      overflow_next = 1'b1;
    end else if (ovf_clr) begin
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge wclk or posedge w_rst) begin
    if (w_rst) begin
      b_wptr_reg      <= '0;
      g_wptr_reg      <= '0;
      full_reg        <= 1'b0;
      almost_full_reg <= 1'b0;
      wlevel_reg      <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      b_wptr_reg      <= b_next;
      g_wptr_reg      <= g_next;
      full_reg        <= full_next;
      almost_full_reg <= almost_full_next;
      wlevel_reg      <= wlevel_next;
      overflow_reg    <= overflow_next;
    end
  end

  assign b_wptr      = b_wptr_reg;
  assign g_wptr      = g_wptr_reg;
  assign full        = full_reg;
  assign almost_full = almost_full_reg;
  assign wlevel      = wlevel_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed self-checking bench for wptr_full_ctrl: reset, fill, overflow,
// read-pointer sync latency, pointer wrap and mid-operation reset.
module tb_wptr_full_ctrl;

  logic       wclk;
  logic       w_rst;
  logic       wen;
  logic [3:0] g_rptr;
  logic       ovf_clr;
  logic [3:0] b_wptr;
  logic [3:0] g_wptr;
  logic       full;
  logic       almost_full;
  logic [3:0] wlevel;
  logic       overflow;

  int n_checks = 0;
  int n_pass   = 0;

  wptr_full_ctrl #(
    .DATA_WIDTH  (8),
    .DEPTH       (8),
    .PTR_WIDTH   (3),
    .AFULL_THRESH(6)
  ) dut (
    .wclk       (wclk),
    .w_rst      (w_rst),
    .wen        (wen),
    .g_rptr     (g_rptr),
    .ovf_clr    (ovf_clr),
    .b_wptr     (b_wptr),
    .g_wptr     (g_wptr),
    .full       (full),
    .almost_full(almost_full),
    .wlevel     (wlevel),
    .overflow   (overflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-22s got=%0h", tag, got);
    end else begin
      $display("FAIL %-22s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [3:0] exp_b;
  logic [3:0] prev_g;

  initial begin
    w_rst   = 1'b0;
    wen     = 1'b0;
    g_rptr  = 4'b0000;
    ovf_clr = 1'b0;

    // Asynchronous reset before any clock edge, with a write pending.
    #3;
    w_rst  = 1'b1;
    wen    = 1'b1;
    g_rptr = 4'b0110;
    #1;
    chk("rst_b_wptr", b_wptr, 0);
    chk("rst_g_wptr", g_wptr, 0);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_wlevel", wlevel, 0);
    chk("rst_overflow", overflow, 0);
    tick();
    tick();
    chk("rst_hold_b_wptr", b_wptr, 0);
    chk("rst_hold_wlevel", wlevel, 0);

    wen    = 1'b0;
    g_rptr = 4'b0000;
    w_rst  = 1'b0;
    tick();
    tick();
    tick();
    chk("idle_b_wptr", b_wptr, 0);
    chk("idle_wlevel", wlevel, 0);

    // Fill eight entries against a read pointer parked at zero.
    wen = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("fill%0d_b_wptr", i), b_wptr, i);
      chk($sformatf("fill%0d_wlevel", i), wlevel, i);
      chk($sformatf("fill%0d_afull", i), almost_full, (i >= 6) ? 1 : 0);
      chk($sformatf("fill%0d_full", i), full, (i == 8) ? 1 : 0);
    end
    chk("fill_g_wptr", g_wptr, 4'b1100);
    chk("fill_overflow", overflow, 0);

    // One more write while full.
    tick();
    chk("ovf_b_wptr", b_wptr, 4'b1000);
    chk("ovf_set", overflow, 1);
    wen = 1'b0;
    tick();
    tick();
    chk("ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 0);
    wen     = 1'b1;
    ovf_clr = 1'b1;
    tick();
    wen     = 1'b0;
    ovf_clr = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared2", overflow, 0);

    // Read pointer advances to binary 3; visible on the third edge.
    g_rptr = 4'b0010;
    tick();
    chk("drain_e1_full", full, 1);
    tick();
    chk("drain_e2_full", full, 1);
    tick();
    chk("drain_e3_full", full, 0);
    chk("drain_e3_wlevel", wlevel, 5);
    chk("drain_e3_afull", almost_full, 0);

    // Read pointer to binary 4, giving occupancy 4, then reset mid-cycle.
    g_rptr = 4'b0110;
    tick();
    tick();
    tick();
    chk("pre_rst_wlevel", wlevel, 4);
    #2;
    w_rst = 1'b1;
    #1;
    chk("mid_rst_b_wptr", b_wptr, 0);
    chk("mid_rst_g_wptr", g_wptr, 0);
    chk("mid_rst_wlevel", wlevel, 0);
    chk("mid_rst_full", full, 0);
    g_rptr = 4'b0000;
    #1;
    w_rst = 1'b0;
    wen   = 1'b1;
    tick();
    wen = 1'b0;
    chk("post_rst_b_wptr", b_wptr, 1);
    chk("post_rst_g_wptr", g_wptr, 4'b0001);
    chk("post_rst_wlevel", wlevel, 1);

    // Sixteen writes with the reader two entries behind; pointer wraps 1111 -> 0000.
    exp_b = 4'd1;
    for (int i = 0; i < 16; i++) begin
      prev_g = g_wptr;
      g_rptr = to_gray(exp_b - 4'd2);
      wen    = 1'b1;
      tick();
      exp_b = exp_b + 4'd1;
      chk($sformatf("wrap%0d_b_wptr", i), b_wptr, exp_b);
      chk($sformatf("wrap%0d_gray_step", i), $countones(g_wptr ^ prev_g), 1);
      chk($sformatf("wrap%0d_full", i), full, 0);
    end
    wen = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
